// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM state type and the
// clock-divider helper. Intended for reuse by the matching transmitter.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Counts 0..DIV-1 and pulses tick for one clk on the wrap. While clear is
// high the count is held at 0 and no tick is produced, so the first tick after
// clear drops lands DIV clocks later.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clear : hold counter at zero
//   tick  : one-clk pulse every DIV clocks
module uart_baud_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled 3-sample majority voting.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rx         : serial line, idles high, asynchronous to clk
//   rx_data    : received word (LSB first on the line)
//   rx_valid   : word available, held until accepted
//   rx_ack     : accept; takes effect when rx_valid && rx_ack at a rising edge
//   frame_err  : a stop bit was sampled low (qualified by rx_valid)
//   parity_err : parity mismatch (qualified by rx_valid)
//   overrun    : sticky, a frame completed while the previous word was pending
//   busy       : high from start-bit detect to the last stop-bit sample
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_FIRST  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_COMMIT = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e state_q, state_d;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, maj, commit, bit_end, complete;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == ST_IDLE),
    .tick  (tick)
  );

  // Synchroniser plus one delay stage for falling-edge detection; all preset
  // to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Two earlier samples are registered; the third is the live value on the
  // commit tick.
  assign maj     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);
  assign commit  = tick && (s_cnt_q == S_COMMIT);
  assign bit_end = tick && (s_cnt_q == S_END);

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    ferr_acc_d   = ferr_acc_q;
    perr_acc_d   = perr_acc_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;

    if (tick) begin
      s_cnt_d = (s_cnt_q == S_END) ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == S_FIRST) smp_d[1] = rx_s_q;
      if (s_cnt_q == S_MID)   smp_d[0] = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        s_cnt_d    = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        ferr_acc_d = 1'b0;
        perr_acc_d = 1'b0;
        if (rx_prev_q && !rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (commit && maj) state_d = ST_IDLE;
        else if (bit_end)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (commit) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (commit) begin
          if (PARITY == PAR_ODD) perr_acc_d = ~(^shift_q ^ maj);
          else                   perr_acc_d = ^shift_q ^ maj;
        end
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (commit) begin
          if (!maj) ferr_acc_d = 1'b1;
          // Finish on the last stop-bit commit rather than the bit end so a
          // start edge immediately following the stop bit is not missed.
          if (stop_cnt_q == STOP_LAST) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        if (bit_end) stop_cnt_d = stop_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete && (!rx_valid_q || rx_ack)) begin
      rx_data_d    = shift_q;
      frame_err_d  = ferr_acc_q | ~maj;
      parity_err_d = perr_acc_q;
      rx_valid_d   = 1'b1;
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
    end

    if (complete && rx_valid_q && !rx_ack) overrun_d = 1'b1;
    else if (rx_valid_q && rx_ack)          overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      s_cnt_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      smp_q        <= '1;
      shift_q      <= '0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      ferr_acc_q   <= ferr_acc_d;
      perr_acc_q   <= perr_acc_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 receiver and one 7E2 receiver (8x
// oversampling), driven by a bit-level line model; expected words and flags
// come from the frame contents the bench chose to send.
module tb_uart_rx_param;

  localparam realtime BIT0 = 1600ns;  // 50 MHz / (625000 * 16) = 5 clocks per tick
  localparam realtime BIT1 = 800ns;   // 50 MHz / (1250000 * 8) = 5 clocks per tick

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       valid0, ferr0, perr0, ovr0, busy0;
  logic       valid1, ferr1, perr1, ovr1, busy1;

  int nvec = 0;
  int nerr = 0;

  always #10ns clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(50_000_000), .BAUD(625_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .rx_data(data0), .rx_valid(valid0),
    .rx_ack(ack0), .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0),
    .busy(busy0)
  );

  uart_rx_param #(
    .CLK_FREQ(50_000_000), .BAUD(1_250_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(8)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_data(data1), .rx_valid(valid1),
    .rx_ack(ack1), .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic set_ack(input int which, input logic v);
    if (which == 0) ack0 = v;
    else            ack1 = v;
  endtask

  // Line model: start bit, data LSB first, even parity (receiver 1 only,
  // optionally inverted), stop bits with one optionally forced low.
  task automatic send_frame(input int which, input logic [8:0] d, input bit flip,
                            input int stop_low_idx);
    realtime bt;
    int      nb, ns;
    logic    pb;
    bt = (which == 0) ? BIT0 : BIT1;
    nb = (which == 0) ? 8 : 7;
    ns = (which == 0) ? 1 : 2;
    set_rx(which, 1'b0);
    #bt;
    for (int i = 0; i < nb; i++) begin
      set_rx(which, d[i]);
      #bt;
    end
    if (which == 1) begin
      pb = ($countones(d[6:0]) % 2 == 1) ? 1'b1 : 1'b0;
      if (flip) pb = ~pb;
      set_rx(which, pb);
      #bt;
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(which, (i == stop_low_idx) ? 1'b0 : 1'b1);
      #bt;
    end
    set_rx(which, 1'b1);
  endtask

  task automatic expect_word(input int which, input logic [8:0] ed, input logic ef,
                             input logic ep, input logic eo, input string tag,
                             input bit do_ack);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 3000 && got !== 1'b1; c++) begin
      @(negedge clk);
      got = (which == 0) ? valid0 : valid1;
    end
    check({tag, ".valid"}, {31'b0, got}, 32'd1);
    check({tag, ".data"}, (which == 0) ? {24'b0, data0} : {25'b0, data1}, {23'b0, ed});
    check({tag, ".ferr"}, {31'b0, (which == 0) ? ferr0 : ferr1}, {31'b0, ef});
    check({tag, ".perr"}, {31'b0, (which == 0) ? perr0 : perr1}, {31'b0, ep});
    check({tag, ".ovr"},  {31'b0, (which == 0) ? ovr0 : ovr1},   {31'b0, eo});
    if (do_ack) begin
      set_ack(which, 1'b1);
      @(negedge clk);
      set_ack(which, 1'b0);
      check({tag, ".cleared"}, {31'b0, (which == 0) ? valid0 : valid1}, 32'd0);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    int         sl;
    bit         fl;

    // Reset state.
    repeat (5) @(negedge clk);
    check("rst.valid0", {31'b0, valid0}, 32'd0);
    check("rst.data0",  {24'b0, data0},  32'd0);
    check("rst.flags0", {28'b0, ferr0, perr0, ovr0, busy0}, 32'd0);
    check("rst.valid1", {31'b0, valid1}, 32'd0);
    check("rst.data1",  {25'b0, data1},  32'd0);
    check("rst.flags1", {28'b0, ferr1, perr1, ovr1, busy1}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame, immediate ack.
    fork send_frame(0, 9'h0A5, 1'b0, -1); join_none
    expect_word(0, 9'h0A5, 1'b0, 1'b0, 1'b0, "a5", 1'b1);
    wait fork;

    // Back-to-back frames with no idle gap.
    fork
      begin
        send_frame(0, 9'h0A5, 1'b0, -1);
        send_frame(0, 9'h05A, 1'b0, -1);
      end
    join_none
    expect_word(0, 9'h0A5, 1'b0, 1'b0, 1'b0, "b2b.first", 1'b1);
    expect_word(0, 9'h05A, 1'b0, 1'b0, 1'b0, "b2b.second", 1'b1);
    wait fork;

    // Even parity, 7 data bits: correct then inverted parity bit.
    fork send_frame(1, 9'h035, 1'b0, -1); join_none
    expect_word(1, 9'h035, 1'b0, 1'b0, 1'b0, "par.good", 1'b1);
    wait fork;
    fork send_frame(1, 9'h035, 1'b1, -1); join_none
    expect_word(1, 9'h035, 1'b0, 1'b1, 1'b0, "par.bad", 1'b1);
    wait fork;

    // Stop bit low.
    send_frame(0, 9'h03C, 1'b0, 0);
    expect_word(0, 9'h03C, 1'b1, 1'b0, 1'b0, "stoplow", 1'b1);
    #BIT0;

    // 400 ns glitch on an idle line is a false start.
    rx0 = 1'b0;
    #200ns;
    check("glitch.busy_hi", {31'b0, busy0}, 32'd1);
    #200ns;
    rx0 = 1'b1;
    #1200ns;
    check("glitch.busy_lo", {31'b0, busy0}, 32'd0);
    check("glitch.novalid", {31'b0, valid0}, 32'd0);

    // Overrun: second word dropped while first is pending.
    send_frame(0, 9'h011, 1'b0, -1);
    expect_word(0, 9'h011, 1'b0, 1'b0, 1'b0, "ovr.first", 1'b0);
    send_frame(0, 9'h022, 1'b0, -1);
    @(negedge clk);
    check("ovr.valid", {31'b0, valid0}, 32'd1);
    check("ovr.data",  {24'b0, data0},  32'h11);
    check("ovr.flag",  {31'b0, ovr0},   32'd1);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    check("ovr.ack_valid", {31'b0, valid0}, 32'd0);
    check("ovr.ack_flag",  {31'b0, ovr0},   32'd0);

    // Break: line held low gives a zero word with frame error, no re-arm.
    rx0 = 1'b0;
    expect_word(0, 9'h000, 1'b1, 1'b0, 1'b0, "break", 1'b1);
    #(BIT0 * 2);
    check("break.noword", {31'b0, valid0}, 32'd0);
    check("break.idle",   {31'b0, busy0},  32'd0);
    rx0 = 1'b1;
    #BIT0;

    // Reset in the middle of a frame discards it.
    fork send_frame(0, 9'h0FF, 1'b0, -1); join_none
    #(BIT0 * 4.5);
    rst = 1'b0;
    #100ns;
    rst = 1'b1;
    wait fork;
    #BIT0;
    check("rstmid.noword", {31'b0, valid0}, 32'd0);
    check("rstmid.idle",   {31'b0, busy0},  32'd0);
    fork send_frame(0, 9'h081, 1'b0, -1); join_none
    expect_word(0, 9'h081, 1'b0, 1'b0, 1'b0, "rstmid.next", 1'b1);
    wait fork;

    // Random frames on the 8N1 receiver.
    for (int i = 0; i < 10; i++) begin
      d  = 9'($urandom_range(0, 255));
      sl = ($urandom_range(0, 4) == 0) ? 0 : -1;
      fork send_frame(0, d, 1'b0, sl); join_none
      expect_word(0, d, (sl >= 0), 1'b0, 1'b0, "rnd0", 1'b1);
      wait fork;
      if (sl >= 0) #BIT0;
    end

    // Random frames on the 7E2 receiver.
    for (int i = 0; i < 12; i++) begin
      d  = 9'($urandom_range(0, 127));
      fl = 1'($urandom_range(0, 1));
      sl = -1;
      if ($urandom_range(0, 4) == 0) sl = int'($urandom_range(0, 1));
      fork send_frame(1, d, fl, sl); join_none
      expect_word(1, d, (sl >= 0), fl, 1'b0, "rnd1", 1'b1);
      wait fork;
      if (sl >= 0) #BIT1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
